// File: rtl/if_id_stage.sv
// IF/ID buffer: 2-entry in-order FIFO of {pc, instr} with combinational decode of the head entry.
// Latency: a pushed pair is at the outputs 1 cycle after its push edge; in_ready depends on occupancy only, so out_ready never reaches it.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [6:0]  out_opcode,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_funct3,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [6:0]  out_funct7,
    output logic [31:0] out_imm,
    output logic        out_illegal
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t     mem [2];
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;
    logic       legal;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // flush wins over push/pop; the same-cycle input pair is simply dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_pc     = out_valid ? mem[rd_ptr].pc    : 32'h0;
    assign out_instr  = out_valid ? mem[rd_ptr].instr : NOP_INSTR;
    assign out_opcode = out_instr[6:0];
    assign out_rd     = out_instr[11:7];
    assign out_funct3 = out_instr[14:12];
    assign out_rs1    = out_instr[19:15];
    assign out_rs2    = out_instr[24:20];
    assign out_funct7 = out_instr[31:25];

    always_comb begin
        out_imm = 32'h0;
        case (out_opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                out_imm = {{20{out_instr[31]}}, out_instr[31:20]};
            7'b0100011:
                out_imm = {{20{out_instr[31]}}, out_instr[31:25], out_instr[11:7]};
            7'b1100011:
                out_imm = {{19{out_instr[31]}}, out_instr[31], out_instr[7],
                           out_instr[30:25], out_instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                out_imm = {out_instr[31:12], 12'h000};
            7'b1101111:
                out_imm = {{11{out_instr[31]}}, out_instr[31], out_instr[19:12],
                           out_instr[20], out_instr[30:21], 1'b0};
            default:
                out_imm = 32'h0;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (out_opcode)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011:
                legal = 1'b1;
            default:
                legal = 1'b0;
        endcase
    end

    assign out_illegal = out_valid && !legal;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: decode vector table streamed through a pop-time scoreboard, plus hand-written reset/backpressure/flush sequences.
module tb_if_id_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic        out_illegal;

    int   tests = 0;
    int   fails = 0;
    vec_t sb[$];
    vec_t cur;
    vec_t tbl [15];
    logic saw_pc10 = 1'b0;

    if_id_stage #(.NOP_INSTR(32'h00000013)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard bookkeeping is done just before the edge, then the clock advances.
    task automatic cycle();
        vec_t e;
        #1;
        if (out_valid && out_pc == 32'h10) saw_pc10 = 1'b1;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop_pc", out_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_pc", out_pc, e.pc);
                    check("sb_instr", out_instr, e.instr);
                    check("sb_imm", out_imm, e.imm);
                    check("sb_illegal", {31'h0, out_illegal}, {31'h0, e.ill});
                    check("sb_opcode", {25'h0, out_opcode}, {25'h0, e.instr[6:0]});
                    check("sb_rd", {27'h0, out_rd}, {27'h0, e.instr[11:7]});
                    check("sb_funct3", {29'h0, out_funct3}, {29'h0, e.instr[14:12]});
                    check("sb_rs1", {27'h0, out_rs1}, {27'h0, e.instr[19:15]});
                    check("sb_rs2", {27'h0, out_rs2}, {27'h0, e.instr[24:20]});
                    check("sb_funct7", {25'h0, out_funct7}, {25'h0, e.instr[31:25]});
                end
            end
            if (in_valid && in_ready) sb.push_back(cur);
        end
        step();
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_pc    = v.pc;
        in_instr = v.instr;
        cur      = v;
    endtask

    task automatic push_one(input vec_t v);
        logic acc;
        acc = 1'b0;
        drive(v);
        for (int k = 0; k < 4 && !acc; k++) begin
            acc = in_ready;
            cycle();
        end
        if (!acc) check("push_timeout", 32'h0, 32'h1);
        in_valid = 1'b0;
    endtask

    task automatic check_empty(input string name);
        check({name, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        check({name, "_in_ready"}, {31'h0, in_ready}, 32'h1);
        check({name, "_out_pc"}, out_pc, 32'h0);
        check({name, "_out_instr"}, out_instr, 32'h00000013);
        check({name, "_out_imm"}, out_imm, 32'h0);
        check({name, "_out_illegal"}, {31'h0, out_illegal}, 32'h0);
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] imm, input logic ill);
        vec_t v;
        v.pc = pc; v.instr = instr; v.imm = imm; v.ill = ill;
        return v;
    endfunction

    initial begin
        logic [31:0] exp_pop [4];
        logic [31:0] pres [4];
        int          idx;
        logic        acc;
        vec_t        addi5;

        tbl[0]  = mk(32'h100, 32'hFE000EE3, 32'hFFFFFFFC, 1'b0); // beq -4
        tbl[1]  = mk(32'h104, 32'h123450B7, 32'h12345000, 1'b0); // lui
        tbl[2]  = mk(32'h108, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        tbl[3]  = mk(32'h10C, 32'h00500093, 32'h00000005, 1'b0); // addi x1,x0,5
        tbl[4]  = mk(32'h110, 32'hFE512C23, 32'hFFFFFFF8, 1'b0); // sw x5,-8(x2)
        tbl[5]  = mk(32'h114, 32'h001000EF, 32'h00000800, 1'b0); // jal x1,+2048
        tbl[6]  = mk(32'h118, 32'hFFDFF06F, 32'hFFFFFFFC, 1'b0); // jal x0,-4
        tbl[7]  = mk(32'h11C, 32'hFFFFF117, 32'hFFFFF000, 1'b0); // auipc
        tbl[8]  = mk(32'h120, 32'h002081B3, 32'h00000000, 1'b0); // add
        tbl[9]  = mk(32'h124, 32'h0FF0000F, 32'h00000000, 1'b0); // fence
        tbl[10] = mk(32'h128, 32'h30529073, 32'h00000305, 1'b0); // csrw mtvec
        tbl[11] = mk(32'h12C, 32'hFFF02083, 32'hFFFFFFFF, 1'b0); // lw x1,-1(x0)
        tbl[12] = mk(32'h130, 32'h00000000, 32'h00000000, 1'b1);
        tbl[13] = mk(32'h134, 32'h000080E7, 32'h00000000, 1'b0); // jalr
        tbl[14] = mk(32'h138, 32'h00208463, 32'h00000008, 1'b0); // beq +8
        addi5 = mk(32'h0, 32'h00500093, 32'h5, 1'b0);

        // reset with a pair presented: nothing may be captured
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'hDEAD; in_instr = 32'h00500093;
        step();
        step();
        check_empty("reset");
        check("reset_rd", {27'h0, out_rd}, 32'h0);
        check("reset_opcode", {25'h0, out_opcode}, 32'h13);
        rst = 1'b0; in_valid = 1'b0;
        step();
        check_empty("idle");

        // first push, then fill
        addi5.pc = 32'h0;
        push_one(addi5);
        check("push0_out_valid", {31'h0, out_valid}, 32'h1);
        check("push0_out_pc", out_pc, 32'h0);
        check("push0_out_rd", {27'h0, out_rd}, 32'h1);
        check("push0_out_imm", out_imm, 32'h5);
        check("push0_in_ready", {31'h0, in_ready}, 32'h1);
        addi5.pc = 32'h4;
        push_one(addi5);
        check("full_in_ready", {31'h0, in_ready}, 32'h0);
        check("full_head_pc", out_pc, 32'h0);

        // drain while streaming in: order preserved
        exp_pop = '{32'h0, 32'h4, 32'h8, 32'hC};
        pres    = '{32'h8, 32'hC, 32'h40, 32'h44};
        idx = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("stream_out_valid", {31'h0, out_valid}, 32'h1);
            check("stream_pop_order", out_pc, exp_pop[i]);
            addi5.pc = pres[idx];
            drive(addi5);
            acc = in_ready;
            cycle();
            if (acc) idx++;
            if (i == 0) check("in_ready_after_pop", {31'h0, in_ready}, 32'h1);
        end
        check("stream_accepted", idx, 3);

        // refill to 2 entries, then flush with a pair presented and out_ready high
        out_ready = 1'b0;
        addi5.pc = 32'h44;
        push_one(addi5);
        check("refill_in_ready", {31'h0, in_ready}, 32'h0);
        addi5.pc = 32'h10;
        drive(addi5);
        out_ready = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check_empty("flush");
        for (int i = 0; i < 4; i++) cycle();
        check("pc10_never_seen", {31'h0, saw_pc10}, 32'h0);

        // decode table streamed back-to-back, checked at pop
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) push_one(tbl[i]);
        for (int i = 0; i < 8 && out_valid; i++) cycle();
        check("drain_done", {31'h0, out_valid}, 32'h0);
        check("sb_empty", sb.size(), 0);

        // reset mid-operation with count=1 and a pair presented
        out_ready = 1'b0;
        addi5.pc = 32'h50;
        push_one(addi5);
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        rst = 1'b1;
        addi5.pc = 32'h54;
        drive(addi5);
        cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        check_empty("mid_reset");
        addi5.pc = 32'h60;
        push_one(addi5);
        check("post_rst_valid", {31'h0, out_valid}, 32'h1);
        check("post_rst_pc", out_pc, 32'h60);
        out_ready = 1'b1;
        cycle();
        check("post_rst_drained", {31'h0, out_valid}, 32'h0);
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have one parameter: NOP_INSTR, default 32'h00000013 (addi x0,x0,0), the instruction presented when the buffer is empty.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  fetch presents a PC/instruction pair.
REQ-005 in_pc  input  32  PC of the fetched word.
REQ-006 in_instr  input  32  fetched instruction word.
REQ-007 in_ready  output  1  buffer can accept a pair this cycle.
REQ-008 flush  input  1  redirect (taken branch/jump); discards all buffered and incoming pairs.
REQ-009 out_valid  output  1  head entry valid toward decode/execute.
REQ-010 out_ready  input  1  consumer accepts the head entry.
REQ-011 out_pc, out_instr  output  32 each  head entry PC and instruction.
REQ-012 out_opcode 7, out_rd 5, out_funct3 3, out_rs1 5, out_rs2 5, out_funct7 7  output  fields of out_instr at bits [6:0],[11:7],[14:12],[19:15],[24:20],[31:25].
REQ-013 out_imm  output  32  sign-extended immediate of out_instr.
REQ-014 out_illegal  output  1  out_instr opcode is not an RV32I base opcode.

Function
REQ-015 The block SHALL be a 2-entry in-order FIFO of {pc, instr} with a 2-bit occupancy count (0..2) and 1-bit read/write pointers wrapping 1->0.
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL be 1 iff count < 2, derived from registered state only (no combinational path from out_ready).
REQ-018 out_valid SHALL be 1 iff count > 0; a pushed pair SHALL appear at the outputs exactly 1 cycle after its push edge.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and preserve order; at count 2 no push can occur (in_ready=0).
REQ-020 Count SHALL never underflow or overflow; pop at count 0 and push at count 2 are impossible by construction.
REQ-021 When flush=1, the next state SHALL be count=0, pointers=0, regardless of in_valid, out_ready, or simultaneous push/pop that cycle; the same-cycle input pair SHALL be discarded.
REQ-022 flush SHALL take priority over push and pop; rst SHALL take priority over flush.
REQ-023 When count=0, out_pc SHALL be 32'h0, out_instr SHALL be NOP_INSTR, and decoded fields SHALL reflect NOP_INSTR.
REQ-024 Field and immediate decode SHALL be combinational from the head entry.
REQ-025 out_imm formats: I for opcodes 0000011, 0010011, 1100111, 1110011; S for 0100011; B for 1100011 (bit0=0); U for 0110111, 0010111 (low 12 bits 0); J for 1101111 (bit0=0); all others 32'h0.
REQ-026 Sign extension SHALL use instr[31] for I, S, B and J formats.
REQ-027 out_illegal SHALL be 1 iff out_valid=1 and opcode is not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011}; when count=0 it SHALL be 0.

Reset
REQ-028 On rst=1 at a clock edge, count, pointers and storage SHALL clear to 0; in the following cycle in_ready=1, out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_illegal=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; pairs presented during reset SHALL NOT be captured.

Verification
REQ-030 Reset then idle -> out_valid=0, in_ready=1, out_instr=32'h00000013, out_imm=0, out_illegal=0.
REQ-031 Push pc=0x0 instr=0x00500093 with out_ready=0 -> next cycle out_valid=1, out_pc=0, out_rd=1, out_imm=5; push pc=0x4 -> in_ready=0 next cycle.
REQ-032 Full buffer, out_ready=1 and in_valid=1 for 4 cycles with pcs 0x8,0xC,... -> pops in order 0x0,0x4,0x8,0xC, in_ready returns to 1 after the first pop, no pair lost or duplicated.
REQ-033 count=2, flush=1 with in_valid=1 (pc=0x10) and out_ready=1 -> next cycle out_valid=0, in_ready=1; pc 0x10 never appears.
REQ-034 Decode: instr 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC; instr 0x123450B7 (lui) -> out_imm=0x12345000; instr 0xFFFFFFFF -> out_illegal=1, out_imm=0.
REQ-035 rst asserted while count=1 and in_valid=1 -> next cycle count=0, out_valid=0; first push after rst deasserts appears 1 cycle later.
